// File: rtl/pe_pkg.sv
// Shared constants and helpers for the registered round-robin priority encoder.
package pe_pkg;

    localparam logic PE_MODE_FIXED = 1'b0;
    localparam logic PE_MODE_RR    = 1'b1;

    // Ceiling log2 with a floor of 1 so a single-source encoder still has a code bit.
    function automatic int unsigned pe_clog2_min1(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) w = i + 32'd1;
        end
        return (w == 0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/priority_encoder_rr_select.sv
// Combinational first-set-bit finder scanning downward from a start index with wrap.
module pe_prio_select
    import pe_pkg::*;
#(
    parameter  int unsigned N_IN   = 8,
    localparam int unsigned CODE_W = pe_clog2_min1(N_IN)
) (
    input  logic [N_IN-1:0]   vec_in,
    input  logic [CODE_W-1:0] start_in,
    output logic              found_c,
    output logic [CODE_W-1:0] index_c
);

    // Walk from farthest to nearest so the bit closest to start_in is written last.
    always_comb begin : scan
        int idx;
        found_c = 1'b0;
        index_c = '0;
        idx     = 0;
        for (int k = int'(N_IN) - 1; k >= 0; k--) begin
            idx = int'(start_in) - k;
            if (idx < 0) idx = idx + int'(N_IN);
            if (vec_in[CODE_W'(idx)]) begin
                found_c = 1'b1;
                index_c = CODE_W'(idx);
            end
        end
    end

endmodule

// File: rtl/priority_encoder_rr.sv
// Registered priority encoder with sticky pending bits, valid/ready output, fixed or round-robin mode.
// Define PE_EDGE_DETECT_EN to latch only rising edges of req_in.
module priority_encoder_rr
    import pe_pkg::*;
#(
    parameter  int unsigned N_IN   = 8,
    localparam int unsigned CODE_W = pe_clog2_min1(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   req_in,
    input  logic [N_IN-1:0]   mask_in,
    input  logic              rr_mode,
    output logic [CODE_W-1:0] code_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [N_IN-1:0]   pending_out
);

    localparam logic [CODE_W-1:0] TOP_IDX = CODE_W'(N_IN - 1);

    logic [CODE_W-1:0] ptr_q;
    logic [N_IN-1:0]   set_c;
    logic [N_IN-1:0]   clr_c;
    logic [N_IN-1:0]   eligible_c;
    logic [CODE_W-1:0] start_c;
    logic              accept_c;
    logic              load_c;
    logic              found_c;
    logic [CODE_W-1:0] sel_c;

`ifdef PE_EDGE_DETECT_EN
    logic [N_IN-1:0] req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_q <= '0;
        else        req_q <= req_in;
    end

    assign set_c = req_in & ~req_q & mask_in;
`else
    assign set_c = req_in & mask_in;
`endif

    // The grant being accepted this cycle is excluded so it cannot be offered twice.
    assign accept_c   = valid_out && ready_in;
    assign clr_c      = accept_c ? (N_IN'(1) << code_out) : '0;
    assign eligible_c = pending_out & mask_in & ~clr_c;
    assign start_c    = (rr_mode == PE_MODE_RR) ? ptr_q : TOP_IDX;
    assign load_c     = !valid_out || ready_in;

    pe_prio_select #(.N_IN(N_IN)) u_select (
        .vec_in   (eligible_c),
        .start_in (start_c),
        .found_c  (found_c),
        .index_c  (sel_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_out <= '0;
            valid_out   <= 1'b0;
            code_out    <= '0;
            ptr_q       <= TOP_IDX;
        end else begin
            pending_out <= (pending_out & ~clr_c) | set_c;
            if (load_c) begin
                valid_out <= found_c;
                code_out  <= found_c ? sel_c : '0;
            end
            if (accept_c && (rr_mode == PE_MODE_RR)) begin
                ptr_q <= (code_out == '0) ? TOP_IDX : CODE_W'(code_out - CODE_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Directed and randomized checks of priority_encoder_rr against a behavioural model.
module tb_priority_encoder_rr;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req_in;
    logic [N-1:0] mask_in;
    logic         rr_mode;
    logic [2:0]   code_out;
    logic         valid_out;
    logic         ready_in;
    logic [N-1:0] pending_out;

    priority_encoder_rr #(.N_IN(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
        .mask_in     (mask_in),
        .rr_mode     (rr_mode),
        .code_out    (code_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .pending_out (pending_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: pending set as bit array, offered grant, round-robin pointer.
    bit m_pend [N];
    bit m_reqq [N];
    bit m_valid;
    int m_code;
    int m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_reqq[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_code  = 0;
        m_ptr   = N - 1;
    endtask

    function automatic logic [N-1:0] model_pending();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently driven, then compare.
    task automatic tick();
        bit accept;
        bit nxt [N];
        bit elig [N];
        bit edge_ok;
        int start;
        int pick;
        accept = m_valid && ready_in;
        for (int i = 0; i < N; i++) begin
            bit granted;
`ifdef PE_EDGE_DETECT_EN
            edge_ok = !m_reqq[i];
`else
            edge_ok = 1'b1;
`endif
            granted = accept && (m_code == i);
            nxt[i]  = (m_pend[i] && !granted) || (req_in[i] && mask_in[i] && edge_ok);
            elig[i] = m_pend[i] && mask_in[i] && !granted;
        end
        start = rr_mode ? m_ptr : N - 1;
        pick  = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start - k + N) % N;
            if (pick < 0 && elig[i]) pick = i;
        end
        if (accept && rr_mode) m_ptr = (m_code == 0) ? N - 1 : m_code - 1;
        if (!m_valid || ready_in) begin
            m_valid = (pick >= 0);
            m_code  = (pick >= 0) ? pick : 0;
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = nxt[i];
            m_reqq[i] = req_in[i];
        end
        @(posedge clk);
        #1;
        chk("model_valid",   32'(valid_out),   32'(m_valid));
        chk("model_code",    32'(code_out),    32'(m_code));
        chk("model_pending", 32'(pending_out), 32'(model_pending()));
    endtask

    initial begin
        int grants;
        rst_n   = 1'b0;
        req_in  = '0;
        mask_in = 8'hFF;
        rr_mode = 1'b0;
        ready_in = 1'b0;
        model_reset();
        #12;
        chk("reset_valid",   32'(valid_out),   32'd0);
        chk("reset_code",    32'(code_out),    32'd0);
        chk("reset_pending", 32'(pending_out), 32'd0);
        rst_n = 1'b1;

        // Empty request
        tick();
        chk("empty_valid",   32'(valid_out),   32'd0);
        chk("empty_pending", 32'(pending_out), 32'd0);

        // Fixed priority drain of a single pulse
        ready_in = 1'b1;
        req_in   = 8'b1010_0100;
        tick();
        req_in = '0;
        chk("fix_latch_pending", 32'(pending_out), 32'hA4);
        chk("fix_latch_valid",   32'(valid_out),   32'd0);
        tick(); chk("fix_g7", 32'({valid_out, code_out}), 32'({1'b1, 3'd7}));
        tick(); chk("fix_g5", 32'({valid_out, code_out}), 32'({1'b1, 3'd5}));
        tick(); chk("fix_g2", 32'({valid_out, code_out}), 32'({1'b1, 3'd2}));
        tick();
        chk("fix_done_valid",   32'(valid_out),   32'd0);
        chk("fix_done_pending", 32'(pending_out), 32'd0);

        // Round-robin with held level requests
        rr_mode = 1'b1;
        req_in  = 8'b1000_0001;
        tick();
        tick(); chk("rr_g7a", 32'({valid_out, code_out}), 32'({1'b1, 3'd7}));
        tick(); chk("rr_g0a", 32'({valid_out, code_out}), 32'({1'b1, 3'd0}));
        tick(); chk("rr_g7b", 32'({valid_out, code_out}), 32'({1'b1, 3'd7}));
        tick(); chk("rr_g0b", 32'({valid_out, code_out}), 32'({1'b1, 3'd0}));
        req_in = '0;
        repeat (3) tick();
        chk("rr_drain_valid", 32'(valid_out), 32'd0);
        rr_mode = 1'b0;

        // Stall holds the offered grant
        ready_in = 1'b0;
        req_in   = 8'h10;
        tick();
        req_in = 8'h80;
        tick();
        req_in = '0;
        chk("stall_g4", 32'({valid_out, code_out}), 32'({1'b1, 3'd4}));
        tick(); tick();
        chk("stall_hold", 32'({valid_out, code_out}), 32'({1'b1, 3'd4}));
        ready_in = 1'b1;
        tick(); chk("stall_next7", 32'({valid_out, code_out}), 32'({1'b1, 3'd7}));
        tick(); chk("stall_empty", 32'(valid_out), 32'd0);

        // Masking
        mask_in = 8'h7F;
        req_in  = 8'h80;
        tick();
        req_in = '0;
        tick();
        chk("mask_ignored_valid",   32'(valid_out),   32'd0);
        chk("mask_ignored_pending", 32'(pending_out), 32'd0);
        mask_in = 8'hFF;
        req_in  = 8'h01;
        tick();
        req_in  = '0;
        mask_in = 8'hFE;
        tick(); tick();
        chk("mask_hold_pending", 32'(pending_out), 32'h01);
        chk("mask_hold_valid",   32'(valid_out),   32'd0);
        mask_in = 8'hFF;
        tick(); chk("mask_restore_g0", 32'({valid_out, code_out}), 32'({1'b1, 3'd0}));
        tick(); chk("mask_restore_empty", 32'(pending_out), 32'd0);

        // Held request on source 1: once with edge detection, repeatedly otherwise
        req_in = 8'h02;
        grants = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (valid_out && code_out == 3'd1) grants++;
        end
        req_in = '0;
        repeat (2) tick();
`ifdef PE_EDGE_DETECT_EN
        chk("held_grants", 32'(grants), 32'd1);
`else
        chk("held_grants_multi", 32'(grants >= 2), 32'd1);
`endif

        // Async reset while a grant is offered
        ready_in = 1'b0;
        req_in   = 8'hFF;
        tick();
        req_in = '0;
        tick();
        chk("prerst_state", 32'({valid_out, code_out, pending_out}), 32'({1'b1, 3'd7, 8'hFF}));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid",   32'(valid_out),   32'd0);
        chk("rst_code",    32'(code_out),    32'd0);
        chk("rst_pending", 32'(pending_out), 32'd0);
        model_reset();
        #3 rst_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            req_in   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            mask_in  = ($urandom_range(0, 4) == 0) ? N'($urandom) : 8'hFF;
            ready_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
